// File: rtl/mac512_pkg.sv
// -----------------------------------------------------------------------------
// mac512_pkg
// Shared definitions for the MAC_512 sequential adder slice:
//   - operand width W, adder slice width SLICE, passes per operation NSLICE
//   - slice index width IDX_W
//   - controller state encoding state_t (IDLE, RUN, DONE)
//   - last_slice(): true when the slice index addresses the top slice
// -----------------------------------------------------------------------------
package mac512_pkg;

    localparam int W      = 512;
    localparam int SLICE  = 128;
    localparam int NSLICE = W / SLICE;
    localparam int IDX_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic last_slice(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(NSLICE - 1);
    endfunction

endpackage

// File: rtl/add512_seq_if.sv
// -----------------------------------------------------------------------------
// add512_seq_if
// Operand/result bus of the sequential 512-bit adder.
//   in_valid/in_ready   : operand handshake (master -> slave)
//   A, B, Ci, ACC       : operands, carry-in, accumulate mode
//   acc_clr             : accumulator clear request
//   out_valid/out_ready : result handshake (slave -> master)
//   S, Cout             : sum and carry-out of bit W-1
// master = operand producer / result consumer, slave = add512_seq.
// -----------------------------------------------------------------------------
interface add512_seq_if;
    import mac512_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         ACC;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;

    modport master (
        output in_valid, A, B, Ci, ACC, acc_clr, out_ready,
        input  in_ready, out_valid, S, Cout
    );

    modport slave (
        input  in_valid, A, B, Ci, ACC, acc_clr, out_ready,
        output in_ready, out_valid, S, Cout
    );

endinterface

// File: rtl/add512_seq_cla128.sv
// -----------------------------------------------------------------------------
// CLA128
// 128-bit carry-lookahead adder slice built from 32 four-bit lookahead groups;
// group carries chain from group to group.
// Ports:
//   A, B  in  128 : addends
//   Ci    in  1   : carry into bit 0
//   S     out 128 : sum
//   Cout  out 1   : carry out of bit 127
//   P, G  out 1   : slice-level propagate / generate for a higher lookahead tier
// -----------------------------------------------------------------------------
module CLA128 (
    input  logic [127:0] A,
    input  logic [127:0] B,
    input  logic         Ci,
    output logic [127:0] S,
    output logic         Cout,
    output logic         P,
    output logic         G
);

    localparam int NGRP = 32;

    logic [127:0]    p;
    logic [127:0]    g;
    logic [127:0]    carry;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_g;
    logic            c_out;
    logic            slice_g;

    assign p = A ^ B;
    assign g = A & B;

    // Group propagate/generate depend only on the operand bits.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NGRP; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Bit carries inside a group are expanded from the group's carry-in;
    // the running scalar carries the group carry to the next group.
    always_comb begin
        logic c_run;
        logic g_run;
        carry   = '0;
        c_run   = Ci;
        g_run   = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            carry[4*k]   = c_run;
            carry[4*k+1] = g[4*k] | (p[4*k] & c_run);
            carry[4*k+2] = g[4*k+1]
                         | (p[4*k+1] & g[4*k])
                         | (p[4*k+1] & p[4*k] & c_run);
            carry[4*k+3] = g[4*k+2]
                         | (p[4*k+2] & g[4*k+1])
                         | (p[4*k+2] & p[4*k+1] & g[4*k])
                         | ((&p[4*k +: 3]) & c_run);
            c_run = grp_g[k] | (grp_p[k] & c_run);
            g_run = grp_g[k] | (grp_p[k] & g_run);
        end
        c_out   = c_run;
        slice_g = g_run;
    end

    assign S    = p ^ carry;
    assign Cout = c_out;
    assign P    = &grp_p;
    assign G    = slice_g;

endmodule

// File: rtl/add512_seq.sv
// -----------------------------------------------------------------------------
// add512_seq
// Multi-cycle 512-bit adder/accumulator. One shared CLA128 slice is stepped
// over the four 128-bit slices, low slice first, with the inter-slice carry
// held in carry_reg. Optionally accumulates into a 512-bit running register.
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset (clears all state incl. acc)
//   bus      slave modport of add512_seq_if:
//            in_valid/in_ready, A, B, Ci, ACC, acc_clr  (operand side)
//            out_valid/out_ready, S, Cout               (result side)
// in_ready/out_valid are registered decodes of the next state, so neither has
// a combinational path from any input.
// -----------------------------------------------------------------------------
module add512_seq
    import mac512_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    add512_seq_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry_reg;
    logic               acc_mode;
    logic [W-1:0]       opa;
    logic [W-1:0]       opb;
    logic [W-1:0]       res;
    logic [W-1:0]       acc;
    logic [W-1:0]       s_reg;
    logic               cout_reg;
    logic               rdy_r;
    logic               vld_r;

    logic               accept;
    logic               last;
    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE-1:0]   sl_s;
    logic               sl_cout;
    logic               unused_p;
    logic               unused_g;
    logic [W-1:0]       sum_full;

    assign accept = (state == IDLE) && rdy_r && bus.in_valid;
    assign last   = (state == RUN) && last_slice(idx);

    // Slice select for the shared adder
    assign sl_a = opa[int'(idx)*SLICE +: SLICE];
    assign sl_b = opb[int'(idx)*SLICE +: SLICE];

    CLA128 u_cla (
        .A    (sl_a),
        .B    (sl_b),
        .Ci   (carry_reg),
        .S    (sl_s),
        .Cout (sl_cout),
        .P    (unused_p),
        .G    (unused_g)
    );

    // On the last pass the top slice comes straight from the adder so the
    // full sum can be published on the same edge it is completed.
    assign sum_full = {sl_s, res[W-SLICE-1:0]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy_r <= 1'b0;
            vld_r <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_r <= (state_nxt == IDLE);
            vld_r <= (state_nxt == DONE);
        end
    end

    // ---- accept stage: latch operands / per-slice stage: step the adder ----
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            acc_mode  <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            acc       <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.acc_clr)
                        acc <= '0;
                    if (accept) begin
                        opa       <= bus.A;
                        // A clear arriving with an accumulate op wins, so the
                        // accumulator operand is zero rather than stale acc.
                        opb       <= bus.ACC ? (bus.acc_clr ? '0 : acc) : bus.B;
                        acc_mode  <= bus.ACC;
                        carry_reg <= bus.Ci;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    res[int'(idx)*SLICE +: SLICE] <= sl_s;
                    carry_reg <= sl_cout;
                    idx       <= idx + IDX_W'(1);
                    if (last) begin
                        s_reg    <= sum_full;
                        cout_reg <= sl_cout;
                        if (acc_mode)
                            acc <= sum_full;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy_r;
    assign bus.out_valid = vld_r;
    assign bus.S         = s_reg;
    assign bus.Cout      = cout_reg;

endmodule

// File: tb/tb_add512_seq.sv
// -----------------------------------------------------------------------------
// tb_add512_seq
// Directed and random checks of add512_seq with a 513-bit reference sum and an
// accumulator model kept in the bench.
// -----------------------------------------------------------------------------
module tb_add512_seq;
    import mac512_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    add512_seq_if bus ();

    add512_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd512();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at posedge+1 with the block idle; returns after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic accm, input logic clr);
        bus.A        = a;
        bus.B        = b;
        bus.Ci       = ci;
        bus.ACC      = accm;
        bus.acc_clr  = clr;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.A        = rnd512();
        bus.B        = rnd512();
        bus.Ci       = 1'b0;
        bus.ACC      = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic seen_rdy);
        lat      = 0;
        seen_rdy = 1'b0;
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            if (bus.in_ready) seen_rdy = 1'b1;
        end
        if (!bus.out_valid) chk("out_valid_timeout", {W'(0), bus.out_valid}, {W'(0), 1'b1});
    endtask

    task automatic finish_op(input int stall);
        repeat (stall) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic accm, input logic clr,
                      input logic [W-1:0] exp_s, input logic exp_c);
        int   lat;
        logic seen;
        start_op(a, b, ci, accm, clr);
        wait_done(lat, seen);
        chk({tag, "_S"},    {1'b0, bus.S},     {1'b0, exp_s});
        chk({tag, "_Cout"}, {W'(0), bus.Cout}, {W'(0), exp_c});
        finish_op(0);
    endtask

    initial begin
        int           lat;
        logic         seen;
        logic [W-1:0] ones;
        logic [W:0]   ref_sum;
        logic [W-1:0] ref_acc;
        logic [W-1:0] a, b, b_eff;
        logic         ci, accm, clr;

        ones          = '1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Ci        = 1'b0;
        bus.ACC       = 1'b0;
        bus.acc_clr   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  W'(bus.in_ready),  '0);
        chk("rst_out_valid", W'(bus.out_valid), '0);
        chk("rst_S",         {1'b0, bus.S},     '0);
        chk("rst_Cout",      W'(bus.Cout),      '0);
        chk("rst_acc",       {1'b0, dut.acc},   '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", W'(bus.in_ready), (W+1)'(1));
        chk("post_rst_state",    W'(dut.state),    W'(IDLE));

        // Plain add with latency and in_ready checks
        start_op(512'd1, 512'd2, 1'b0, 1'b0, 1'b0);
        wait_done(lat, seen);
        chk("plain_lat",      (W+1)'(lat),     (W+1)'(4));
        chk("plain_in_ready", W'(seen),        '0);
        chk("plain_S",        {1'b0, bus.S},   (W+1)'(3));
        chk("plain_Cout",     W'(bus.Cout),    '0);
        finish_op(0);
        chk("plain_back_idle", W'(bus.in_ready), (W+1)'(1));

        // Carry ripple through every slice and across slice 0 -> 1
        op("ripple_full", ones, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        op("ripple_s01", {384'd0, {128{1'b1}}}, 512'd1, 1'b0, 1'b0, 1'b0,
           {383'd0, 1'b1, 128'd0}, 1'b0);
        op("top_cout", {1'b1, 511'd0}, {1'b1, 511'd0}, 1'b1, 1'b0, 1'b0, 512'd1, 1'b1);

        // Accumulate
        bus.acc_clr = 1'b1;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        chk("acc_cleared", {1'b0, dut.acc}, '0);
        op("acc1", 512'd5, 512'd99, 1'b0, 1'b1, 1'b0, 512'd5,  1'b0);
        op("acc2", 512'd5, 512'd99, 1'b0, 1'b1, 1'b0, 512'd10, 1'b0);
        op("acc3", 512'd5, 512'd99, 1'b0, 1'b1, 1'b0, 512'd15, 1'b0);
        chk("acc_15", {1'b0, dut.acc}, (W+1)'(15));
        op("acc_plain", 512'd1, 512'd1, 1'b0, 1'b0, 1'b0, 512'd2, 1'b0);
        chk("acc_kept", {1'b0, dut.acc}, (W+1)'(15));
        op("acc_clr_acc", 512'd7, 512'd50, 1'b0, 1'b1, 1'b1, 512'd7, 1'b0);
        chk("acc_7", {1'b0, dut.acc}, (W+1)'(7));

        // Backpressure: result held, in_valid and acc_clr ignored in DONE
        start_op(512'd9, 512'd1, 1'b0, 1'b0, 1'b0);
        wait_done(lat, seen);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.acc_clr  = 1'b1;
            bus.ACC      = 1'b1;
            bus.A        = rnd512();
            @(posedge clk); #1;
            chk("bp_S",         {1'b0, bus.S},     (W+1)'(10));
            chk("bp_Cout",      W'(bus.Cout),      '0);
            chk("bp_out_valid", W'(bus.out_valid), (W+1)'(1));
            chk("bp_in_ready",  W'(bus.in_ready),  '0);
        end
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.ACC      = 1'b0;
        chk("bp_acc_kept", {1'b0, dut.acc}, (W+1)'(7));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_state_idle", W'(dut.state),     W'(IDLE));
        chk("bp_out_valid0", W'(bus.out_valid), '0);
        chk("bp_in_ready1",  W'(bus.in_ready),  (W+1)'(1));
        chk("bp_S_kept",     {1'b0, bus.S},     (W+1)'(10));

        // Reset during the second RUN cycle aborts the operation
        start_op(512'd100, 512'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", W'(bus.out_valid), '0);
        chk("mid_rst_S",         {1'b0, bus.S},     '0);
        chk("mid_rst_acc",       {1'b0, dut.acc},   '0);
        chk("mid_rst_state",     W'(dut.state),     W'(IDLE));
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("mid_rst_no_valid", W'(bus.out_valid), '0);
        end
        op("post_rst", 512'd3, 512'd4, 1'b0, 1'b0, 1'b0, 512'd7, 1'b0);

        // Random regression against the bench reference
        ref_acc = '0;
        for (int n = 0; n < 1000; n++) begin
            a    = ($urandom_range(0, 7) == 0) ? ones : rnd512();
            b    = ($urandom_range(0, 7) == 0) ? ~a  : rnd512();
            ci   = 1'($urandom);
            accm = 1'($urandom);
            clr  = ($urandom_range(0, 15) == 0);
            if (clr) ref_acc = '0;
            b_eff   = accm ? ref_acc : b;
            ref_sum = {1'b0, a} + {1'b0, b_eff} + (W+1)'(ci);
            if (accm) ref_acc = ref_sum[W-1:0];
            start_op(a, b, ci, accm, clr);
            wait_done(lat, seen);
            chk("rnd_S",    {1'b0, bus.S},   {1'b0, ref_sum[W-1:0]});
            chk("rnd_Cout", W'(bus.Cout),    W'(ref_sum[W]));
            finish_op($urandom_range(0, 3));
        end
        chk("rnd_acc", {1'b0, dut.acc}, {1'b0, ref_acc});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
